// File: rtl/bus_requester_if.sv
// Handshake, data and arbitration signals of bus_requester, bundled so the
// requester (master) and its surrounding logic (slave) share one connection.
interface bus_requester_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 4
);
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          rq;
    logic          gt;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic          done;
    logic          err;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_len, src_valid, src_data, gt,
        output cmd_ready, src_ready, rq, bus_valid, bus_data, done, err, busy
    );

    modport slave (
        output cmd_valid, cmd_len, src_valid, src_data, gt,
        input  cmd_ready, src_ready, rq, bus_valid, bus_data, done, err, busy
    );
endinterface

// File: rtl/bus_requester.sv
// Burst requester: takes a local burst command, requests the shared bus from
// an arbiter, streams local beats while granted and releases the bus cleanly.
module bus_requester #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LW  = 4,
    parameter int unsigned TMO = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_requester_if.master bus
);
    localparam int unsigned   WW        = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        REL
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rq_q;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          beat;

    assign beat = (state_q == XFER) && bus.gt && bus.src_valid;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len != '0) begin
                        beat_d  = bus.cmd_len;
                        wait_d  = '0;
                        state_d = REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // A grant on the last allowed wait cycle still wins over the timeout.
                if (bus.gt) begin
                    state_d = XFER;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = REL;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            XFER: begin
                if (!bus.gt) begin
                    err_d   = 1'b1;
                    state_d = REL;
                end else if (bus.src_valid && beat_q != '0) begin
                    beat_d = beat_q - LW'(1);
                    if (beat_q == LW'(1)) begin
                        done_d  = 1'b1;
                        state_d = REL;
                    end
                end
            end
            REL: begin
                if (!bus.gt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rq is a flop fed from the next state so it can never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            rq_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            rq_q    <= (state_d == REQ) || (state_d == XFER);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.rq        = rq_q;
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.bus_valid = beat;
    assign bus.src_ready = beat;
    assign bus.bus_data  = beat ? bus.src_data : {DW{1'b0}};
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    a_done_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q && err_q));
    a_xfer_cnt_live : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == XFER) |-> (beat_q != '0));
endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: directed vector table, randomized
// bursts against a transaction-level prediction, plus queue and reset sequences.
module tb_bus_requester;
    localparam int unsigned DW  = 8;
    localparam int unsigned LW  = 4;
    localparam int unsigned TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bus_requester_if #(.DW(DW), .LW(LW)) bif ();

    bus_requester #(.DW(DW), .LW(LW), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        int          len;
        int          gdly;
        logic [31:0] stall;
        int          drop;
        int          hold;
        int          e_beats;
        int          e_done;
        int          e_err;
        int          e_rq;
        int          e_rel;
    } vec_t;

    typedef struct {
        int beats;
        int done;
        int err;
        int rq;
        int rel;
        int bad_data;
        int viol;
        int tmo;
    } obs_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(inout obs_t o);
        if (bif.bus_valid) begin
            o.beats++;
            if (bif.bus_data != bif.src_data) o.bad_data++;
        end
        if (bif.src_ready != bif.bus_valid) o.viol++;
        if (!bif.rq && bif.bus_valid)       o.viol++;
        if (bif.busy && bif.cmd_ready)      o.viol++;
        if (bif.done && bif.err)            o.viol++;
        if (bif.done)                       o.done++;
        if (bif.err)                        o.err++;
        if (bif.rq)                         o.rq++;
        if (bif.busy && !bif.rq)            o.rel++;
    endtask

    // Reactive arbiter/source: grants after gdly waiting cycles, drops grant
    // once drop beats were seen, stalls per mask, holds gt for hold REL cycles.
    task automatic run_burst(input int len, input int gdly, input logic [31:0] stall,
                             input int drop, input int hold, output obs_t o);
        int req_n = 0;
        int xc    = 0;
        int rel_n = 0;
        bit granted = 1'b0;
        bit rq_now, busy_now;
        o = '{default: 0};
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = LW'(len);
        bif.gt        = 1'b0;
        bif.src_valid = 1'($urandom_range(0, 1));
        bif.src_data  = DW'($urandom);
        #1;
        if (!bif.cmd_ready) o.viol++;
        observe(o);
        nxt();
        bif.cmd_valid = 1'b0;
        o.tmo = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rq_now   = bif.rq;
            busy_now = bif.busy;
            bif.src_data = DW'($urandom);
            if (rq_now && !granted) begin
                bif.gt        = (req_n >= gdly);
                granted       = (req_n >= gdly);
                bif.src_valid = 1'($urandom_range(0, 1));
                req_n++;
            end else if (rq_now) begin
                bif.gt        = (o.beats < drop);
                bif.src_valid = (xc < 32) ? !stall[xc] : 1'b1;
                xc++;
            end else if (busy_now) begin
                bif.gt        = (rel_n < hold);
                bif.src_valid = 1'($urandom_range(0, 1));
                rel_n++;
            end else begin
                bif.gt        = 1'b0;
                bif.src_valid = 1'($urandom_range(0, 1));
            end
            #1;
            observe(o);
            if (!bif.busy) begin
                o.tmo = 0;
                break;
            end
            nxt();
        end
        bif.gt = 1'b0;
        nxt();
    endtask

    // Outcome of one burst derived directly from the beat, grant and release rules.
    task automatic predict(input int len, input int gdly, input logic [31:0] stall,
                           input int drop, input int hold,
                           output int b, output int d, output int e, output int r, output int rl);
        b = 0; d = 0; e = 0; r = 0; rl = 0;
        if (len == 0) begin
            d = 1;
        end else if (gdly >= int'(TMO)) begin
            r  = TMO;
            e  = 1;
            rl = hold + 1;
        end else begin
            r = gdly + 1;
            for (int c = 0; c < 64; c++) begin
                r++;
                if (b >= drop) begin
                    e = 1;
                    break;
                end
                if (c < 32 && stall[c]) continue;
                b++;
                if (b == len) begin
                    d = 1;
                    break;
                end
            end
            rl = hold + 1;
        end
    endtask

    task automatic check_obs(input string tag, input obs_t o, input int b, input int d,
                             input int e, input int r, input int rl);
        chk({tag, "_beats"}, o.beats, b);
        chk({tag, "_done"},  o.done,  d);
        chk({tag, "_err"},   o.err,   e);
        chk({tag, "_rq"},    o.rq,    r);
        chk({tag, "_rel"},   o.rel,   rl);
        chk({tag, "_data"},  o.bad_data, 0);
        chk({tag, "_rules"}, o.viol, 0);
        chk({tag, "_budget"}, o.tmo, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tv[9];
        obs_t o;
        int   eb, ed, ee, er, erl;
        int   acc;

        tv[0] = '{len:3,  gdly:2,  stall:32'h0, drop:99, hold:0, e_beats:3,  e_done:1, e_err:0, e_rq:6,  e_rel:1};
        tv[1] = '{len:4,  gdly:0,  stall:32'h2, drop:99, hold:0, e_beats:4,  e_done:1, e_err:0, e_rq:6,  e_rel:1};
        tv[2] = '{len:5,  gdly:99, stall:32'h0, drop:99, hold:0, e_beats:0,  e_done:0, e_err:1, e_rq:16, e_rel:1};
        tv[3] = '{len:5,  gdly:1,  stall:32'h0, drop:2,  hold:0, e_beats:2,  e_done:0, e_err:1, e_rq:5,  e_rel:1};
        tv[4] = '{len:2,  gdly:0,  stall:32'h0, drop:99, hold:3, e_beats:2,  e_done:1, e_err:0, e_rq:3,  e_rel:4};
        tv[5] = '{len:0,  gdly:0,  stall:32'h0, drop:99, hold:0, e_beats:0,  e_done:1, e_err:0, e_rq:0,  e_rel:0};
        tv[6] = '{len:15, gdly:0,  stall:32'h0, drop:99, hold:0, e_beats:15, e_done:1, e_err:0, e_rq:16, e_rel:1};
        tv[7] = '{len:1,  gdly:15, stall:32'h0, drop:99, hold:0, e_beats:1,  e_done:1, e_err:0, e_rq:17, e_rel:1};
        tv[8] = '{len:3,  gdly:0,  stall:32'h0, drop:0,  hold:0, e_beats:0,  e_done:0, e_err:1, e_rq:2,  e_rel:1};

        bif.cmd_valid = 1'b0;
        bif.cmd_len   = '0;
        bif.src_valid = 1'b0;
        bif.src_data  = '0;
        bif.gt        = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_rq",        bif.rq,        0);
        chk("rst_busy",      bif.busy,      0);
        chk("rst_cmd_ready", bif.cmd_ready, 1);
        chk("rst_done",      bif.done,      0);
        chk("rst_err",       bif.err,       0);
        chk("rst_bus_valid", bif.bus_valid, 0);
        chk("rst_src_ready", bif.src_ready, 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        for (int i = 0; i < 9; i++) begin
            run_burst(tv[i].len, tv[i].gdly, tv[i].stall, tv[i].drop, tv[i].hold, o);
            check_obs($sformatf("vec%0d", i), o, tv[i].e_beats, tv[i].e_done,
                      tv[i].e_err, tv[i].e_rq, tv[i].e_rel);
        end

        for (int i = 0; i < 60; i++) begin
            int          len, gd, dr, hd;
            logic [31:0] st;
            len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 15));
            gd  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, TMO + 2))
                                              : int'($urandom_range(0, 4));
            dr  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : 99;
            hd  = int'($urandom_range(0, 3));
            st  = $urandom & $urandom;
            predict(len, gd, st, dr, hd, eb, ed, ee, er, erl);
            run_burst(len, gd, st, dr, hd, o);
            check_obs($sformatf("rnd%0d", i), o, eb, ed, ee, er, erl);
        end

        // Second command held on cmd_valid while the arbiter keeps gt high in REL.
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = LW'(1);
        bif.gt        = 1'b0;
        bif.src_valid = 1'b1;
        bif.src_data  = 8'h3C;
        #1;
        chk("q_ready_idle", bif.cmd_ready, 1);
        nxt();
        bif.cmd_len = LW'(2);
        bif.gt      = 1'b1;
        #1;
        chk("q_rq_req",    bif.rq,        1);
        chk("q_ready_req", bif.cmd_ready, 0);
        nxt();
        bif.src_data = 8'hA5;
        #1;
        chk("q_beat",      bif.bus_valid, 1);
        chk("q_beat_data", bif.bus_data,  8'hA5);
        nxt();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("q_rel%0d_rq", i),    bif.rq,        0);
            chk($sformatf("q_rel%0d_ready", i), bif.cmd_ready, 0);
            chk($sformatf("q_rel%0d_busy", i),  bif.busy,      1);
            chk($sformatf("q_rel%0d_done", i),  bif.done,      (i == 0) ? 1 : 0);
            nxt();
        end
        bif.gt = 1'b0;
        #1;
        chk("q_rel_last_busy",  bif.busy,      1);
        chk("q_rel_last_ready", bif.cmd_ready, 0);
        nxt();
        #1;
        chk("q_idle_ready", bif.cmd_ready, 1);
        chk("q_idle_rq",    bif.rq,        0);
        nxt();
        bif.cmd_valid = 1'b0;
        bif.gt        = 1'b1;
        #1;
        chk("q_second_rq", bif.rq, 1);
        nxt();
        nxt();
        #1;
        chk("q_second_beat2", bif.bus_valid, 1);
        nxt();
        bif.gt = 1'b0;
        #1;
        chk("q_second_done", bif.done, 1);
        nxt();
        #1;
        chk("q_second_idle", bif.busy, 0);
        nxt();

        // Reset dropped in the middle of a granted burst, between clock edges.
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = LW'(8);
        bif.gt        = 1'b0;
        nxt();
        bif.cmd_valid = 1'b0;
        bif.gt        = 1'b1;
        bif.src_valid = 1'b1;
        nxt();
        nxt();
        nxt();
        #1;
        chk("r_pre_rq",   bif.rq,        1);
        chk("r_pre_beat", bif.bus_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r_rq",        bif.rq,        0);
        chk("r_bus_valid", bif.bus_valid, 0);
        chk("r_src_ready", bif.src_ready, 0);
        chk("r_busy",      bif.busy,      0);
        chk("r_cmd_ready", bif.cmd_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bif.gt        = 1'b0;
        bif.src_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1;
            acc += int'(bif.done) + int'(bif.err) + int'(bif.rq) + int'(bif.busy);
        end
        chk("r_post_quiet", acc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameter DW, default 8: width of the data beat.
REQ-002 Parameter LW, default 4: width of the burst-length field.
REQ-003 Parameter TMO, default 16: number of grant-wait cycles before the request is abandoned.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports (name, direction, width, meaning):
  clk  in  1  clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous reset, active low.
  cmd_valid  in  1  local burst request.
  cmd_len  in  LW  burst length in beats; 0 means no transfer.
  cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
  src_valid  in  1  local data beat available.
  src_data  in  DW  local data beat.
  src_ready  out  1  beat consumed this cycle.
  rq  out  1  request line to the arbiter.
  gt  in  1  grant line from the arbiter.
  bus_valid  out  1  beat driven on the bus this cycle.
  bus_data  out  DW  bus data.
  done  out  1  one-cycle pulse: burst completed.
  err  out  1  one-cycle pulse: burst aborted.
  busy  out  1  high in every state except IDLE.

Function
REQ-006 FSM states SHALL be IDLE, REQ, XFER and REL, held in a registered state variable.
REQ-007 IDLE behaviour: cmd_ready=1; rq=0.
  - On cmd_valid with cmd_len!=0: latch cmd_len into the beat counter, clear the wait counter, go to REQ.
  - On cmd_valid with cmd_len==0: accept the command, pulse done on the next cycle, stay in IDLE, never assert rq.
REQ-008 REQ behaviour: rq=1; cmd_ready=0.
  - On gt=1 sampled: go to XFER.
  - Otherwise: increment the wait counter.
  - When the wait counter reaches TMO-1 with gt=0: pulse err on the next cycle and go to REL.
REQ-009 XFER behaviour: rq=1.
  - Beat rule: bus_valid = src_ready = (gt & src_valid); bus_data = src_data, combinationally.
  - Each beat decrements the beat counter.
  - When the beat counter reaches 0 on a beat: pulse done on the next cycle, go to REL.
  - A src_valid=0 cycle is a stall: no beat, counter unchanged, rq held.
REQ-010 If gt=0 in XFER (grant lost): no beat that cycle; pulse err on the next cycle; go to REL.
REQ-011 REL behaviour: rq=0, for at least one cycle.
  - Stay in REL while gt=1.
  - Return to IDLE on the first cycle gt=0 is sampled.
  - This lets the arbiter return to its idle state before any new request.
REQ-012 rq SHALL be a registered output, glitch-free, and SHALL never be high in IDLE or REL.
REQ-013 bus_valid, src_ready, done and err SHALL be 0 in every state not named above as driving them.
REQ-014 done and err SHALL never be high in the same cycle.
REQ-015 The beat counter is LW bits wide and SHALL never wrap; the maximum burst is 2^LW-1 beats.
REQ-016 The wait counter SHALL be wide enough to hold TMO-1 and SHALL saturate.

Reset
REQ-017 While rst_n=0, immediately and independent of clk:
  - state = IDLE;
  - rq, done, err, busy, bus_valid and src_ready = 0;
  - both counters = 0;
  - cmd_ready = 1 (combinational from IDLE).
REQ-018 Reset asserted mid-burst SHALL drop rq asynchronously; no done or err pulse SHALL follow reset release.

Verification
REQ-019 cmd_len=3, gt rises 2 cycles after rq, src_valid always 1 -> exactly 3 bus_valid beats carrying src_data values; done pulses once; rq low the cycle after the 3rd beat.
REQ-020 cmd_len=4, src_valid low on the 2nd beat cycle -> 4 beats over 5 grant cycles; rq held throughout; done once.
REQ-021 TMO=16, gt held 0 -> rq high for 16 cycles, err pulses once, return to IDLE, zero bus_valid beats.
REQ-022 cmd_len=5, gt drops after 2 beats -> err pulse, rq low next cycle, no further beats, done never asserted.
REQ-023 gt held high for 3 cycles after the burst ends -> block stays in REL with rq=0 and cmd_ready=0 until gt=0; a second queued command starts only after that.
REQ-024 rst_n pulsed low during XFER -> rq, bus_valid and busy go to 0 without a clock edge; cmd_ready=1; no done or err pulse after rst_n returns high.
